hd44780_nybble_receiver: RTL
============================

Name: hd44780_nybble_receiver

Overview:
LCD-side decoder for the HD44780 4-bit write bus that the controller and nybble sender drive. It samples RS/E/DATA, tracks 8-bit vs 4-bit interface mode the way the real controller does, and reassembles bytes. It checks every E pulse against the TAS/PWEH/TCYCE tick budgets and raises sticky error flags. It is used as an in-FPGA loopback checker on the lcd_* pins and as the bus responder model in simulation benches.

Parameters:
SYNC_STAGES, 2, input synchronizer flops per bus signal; 0 selects combinational pass-through for internal loopback.
COUNT_BITS, `H4NS_COUNT_BITS, width of the timing counters; they saturate at all-ones.
TICKS_TAS, `H4NS_TICKS_TAS, minimum ticks RS must be stable before E rises.
TICKS_PWEH, `H4NS_TICKS_PWEH, minimum ticks E must be high.
TICKS_TCYCE, `H4NS_TICKS_TCYCE, minimum ticks from one E rise to the next.

Ports:
CLK_I  in  1  system clock
RST_I  in  1  synchronous reset, active high
lcd_rs  in  1  register select from bus
lcd_e  in  1  enable from bus
lcd_data  in  4  data nybble from bus
err_clr  in  1  one-cycle pulse; clears all sticky error flags
byte_stb  out  1  one-cycle pulse: byte_data/byte_rs are valid
byte_data  out  8  reassembled byte
byte_rs  out  1  RS of the completed byte
mode_4bit  out  1  1 = decoder is in 4-bit interface mode
hi_nybble_pending  out  1  4-bit mode, first nybble captured, second not yet received
err_tas  out  1  sticky: RS setup violation
err_pweh  out  1  sticky: E high-time violation
err_tcyce  out  1  sticky: E cycle-time violation
err_data  out  1  sticky: DATA or RS changed while E was high
err_rs_split  out  1  sticky: two nybbles of one byte had different RS

Behaviour:
- Reset: all outputs 0, byte_data = 0x00, mode_4bit = 0 (8-bit mode, as at LCD power-up), first-rise flag set, counters 0.
- rs_s/e_s/d_s: inputs after SYNC_STAGES flops. e_d is registered e_s. rise = ~e_d & e_s; fall = e_d & ~e_s.
- as_cnt: cleared to 0 on any cycle rs_s differs from its registered copy, else increments (saturating). On rise, if as_cnt < TICKS_TAS, set err_tas.
- hi_cnt: loaded with 1 on rise, increments while e_s is high. On fall, if hi_cnt < TICKS_PWEH, set err_pweh.
- cyc_cnt: loaded with 1 on rise, increments every cycle. On rise with the first-rise flag clear, if cyc_cnt < TICKS_TCYCE, set err_tcyce. The first rise after reset is never checked and clears the flag.
- While e_s is high and not on the rise cycle: any change of d_s or rs_s sets err_data.
- Capture: on fall, take nybble = d_s (value on that edge) and rs = rs_s.
- 8-bit mode: each fall completes a byte: byte_data = {nybble, 4'h0}, byte_rs = rs. If rs = 0 and nybble = 4'h2, set mode_4bit = 1 on the same edge.
- 4-bit mode, pending = 0: store the high nybble and rs, set hi_nybble_pending. No strobe.
- 4-bit mode, pending = 1: byte_data = {stored, nybble}, byte_rs = stored rs, clear pending. If the two rs values differ, set err_rs_split. If byte_rs = 0 and byte_data[7:4] = 4'h3 (function set with DL = 1), clear mode_4bit.
- byte_stb is registered and high for exactly one cycle. Latency is SYNC_STAGES+1 cycles from lcd_e low to byte_stb high.
- Error flags are sticky until err_clr or RST_I. If err_clr and a new violation occur in the same cycle, the violation wins and the flag stays 1.
- Error checks never block capture; a violating pulse still produces its nybble or byte.
- A fall with no observed rise (E high out of reset) is ignored: no capture, no checks.
- RST_I mid-byte discards the pending nybble and returns to 8-bit mode.
- Counters saturate and never wrap, so long idle gaps never produce false TCYCE or TAS errors.

Decomposition:
- Tick constants stay in hd44780_build_config.inc / hd44780_sim_config.inc. Add an hd44780_defs include for the function-set codes 4'h2 and 4'h3.
- One sub-module: hd44780_sync, an N-stage synchronizer (width parameter, 0 = pass-through), instantiated once for {rs, e, data}.

Test Plan:
- Reset, then E pulse RS=0 DATA=0x3, 25 ticks high -> byte_stb with 0x30, rs=0, mode_4bit=0, no errors; latency exactly SYNC_STAGES+1.
- Init sequence 0x3, 0x3, 0x3, 0x2 (8-bit-mode pulses, 50-tick spacing), then nybbles 0x2, 0x8 -> four 8-bit strobes; mode_4bit=1 after the fourth; one byte 0x28 rs=0.
- 4-bit mode, nybbles 0x4, 0x1 with RS=1 -> byte 0x41 rs=1; hi_nybble_pending high between them.
- Pulses with E high 10 ticks, E rises 30 ticks apart, RS changed 1 tick before E rise -> err_pweh, err_tcyce, err_tas all 1; bytes still strobed; err_clr -> all 0.
- DATA toggled mid-pulse, and RS=0 / RS=1 across a nybble pair -> err_data=1, err_rs_split=1; byte_rs equals first nybble's RS.
- 4-bit mode, RS=0 byte 0x30 -> mode_4bit clears. Later, RST_I asserted with hi_nybble_pending=1 -> pending 0, mode_4bit 0, no strobe.

Source files
------------

// File: rtl/hd44780_nybble_receiver_pkg.sv
// Shared constants and types for the HD44780 4-bit bus receiver.
// Tick budgets are in CLK_I cycles.
package hd44780_nybble_receiver_pkg;

  localparam int H4NS_COUNT_BITS  = 8;
  localparam int H4NS_TICKS_TAS   = 2;
  localparam int H4NS_TICKS_PWEH  = 20;
  localparam int H4NS_TICKS_TCYCE = 40;

  // Function-set high nybbles: DL=0 enters 4-bit, DL=1 returns to 8-bit.
  localparam logic [3:0] FS_4BIT = 4'h2;
  localparam logic [3:0] FS_8BIT = 4'h3;

  typedef enum logic [1:0] {
    ST_8BIT = 2'd0,
    ST_4HI  = 2'd1,
    ST_4LO  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/hd44780_sync.sv
// N-stage input synchronizer; STAGES = 0 is a plain wire.
// Flops carry no reset so bus history survives RST_I.
module hd44780_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_pass
    assign q = d;
  end else begin : g_sync
    logic [WIDTH-1:0] ff [STAGES];

    always_ff @(posedge clk) begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++)
        ff[i] <= ff[i-1];
    end

    assign q = ff[STAGES-1];
  end

endmodule

// File: rtl/hd44780_nybble_receiver.sv
// HD44780 4-bit write-bus decoder: mode tracking,
// byte reassembly and E-pulse timing checks.
module hd44780_nybble_receiver
  import hd44780_nybble_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_BITS  = H4NS_COUNT_BITS,
  parameter int TICKS_TAS   = H4NS_TICKS_TAS,
  parameter int TICKS_PWEH  = H4NS_TICKS_PWEH,
  parameter int TICKS_TCYCE = H4NS_TICKS_TCYCE
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       lcd_rs,
  input  logic       lcd_e,
  input  logic [3:0] lcd_data,
  input  logic       err_clr,
  output logic       byte_stb,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic       mode_4bit,
  output logic       hi_nybble_pending,
  output logic       err_tas,
  output logic       err_pweh,
  output logic       err_tcyce,
  output logic       err_data,
  output logic       err_rs_split
);

  localparam int CB = COUNT_BITS;
  localparam logic [CB-1:0] TAS_C = CB'(TICKS_TAS);
  localparam logic [CB-1:0] PWEH_C = CB'(TICKS_PWEH);
  localparam logic [CB-1:0] TCYC_C = CB'(TICKS_TCYCE);
  localparam logic [CB-1:0] ONE_C = CB'(1);

  logic [5:0] bus_s;
  logic       rs_s, e_s;
  logic [3:0] d_s;

  hd44780_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (6)
  ) u_sync (
    .clk (CLK_I),
    .d   ({lcd_rs, lcd_e, lcd_data}),
    .q   (bus_s)
  );

  assign rs_s = bus_s[5];
  assign e_s  = bus_s[4];
  assign d_s  = bus_s[3:0];

  logic          e_d, rs_d;
  logic [3:0]    d_d;
  logic          armed, first_rise;
  logic [CB-1:0] as_cnt, hi_cnt, cyc_cnt;
  logic          rise, fall, cap;

  assign rise = ~e_d & e_s;
  assign fall = e_d & ~e_s;
  assign cap  = fall & armed;

  logic tas_v, pweh_v, tcyc_v, data_v, split_v;

  assign tas_v  = rise & (as_cnt < TAS_C);
  assign pweh_v = cap & (hi_cnt < PWEH_C);
  assign tcyc_v = rise & ~first_rise &
                  (cyc_cnt < TCYC_C);
  assign data_v = armed & e_s &
                  ((d_s != d_d) | (rs_s != rs_d));

  rx_state_t  state, state_n;
  logic [3:0] hi_nyb;
  logic       hi_rs;
  logic       stb_n, rs_n;
  logic [7:0] data_n;

  always_comb begin
    state_n = state;
    stb_n   = 1'b0;
    data_n  = byte_data;
    rs_n    = byte_rs;
    split_v = 1'b0;
    if (cap) begin
      case (state)
        ST_8BIT: begin
          stb_n  = 1'b1;
          data_n = {d_s, 4'h0};
          rs_n   = rs_s;
          if (!rs_s && d_s == FS_4BIT)
            state_n = ST_4HI;
        end
        ST_4HI: state_n = ST_4LO;
        ST_4LO: begin
          stb_n   = 1'b1;
          data_n  = {hi_nyb, d_s};
          rs_n    = hi_rs;
          split_v = hi_rs != rs_s;
          if (!hi_rs && hi_nyb == FS_8BIT)
            state_n = ST_8BIT;
          else
            state_n = ST_4HI;
        end
        default: state_n = ST_8BIT;
      endcase
    end
  end

  // e_d resets high so E already high out of reset is not a rise.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      e_d          <= 1'b1;
      rs_d         <= 1'b0;
      d_d          <= 4'h0;
      armed        <= 1'b0;
      first_rise   <= 1'b1;
      as_cnt       <= '0;
      hi_cnt       <= '0;
      cyc_cnt      <= '0;
      state        <= ST_8BIT;
      hi_nyb       <= 4'h0;
      hi_rs        <= 1'b0;
      byte_stb     <= 1'b0;
      byte_data    <= 8'h00;
      byte_rs      <= 1'b0;
      err_tas      <= 1'b0;
      err_pweh     <= 1'b0;
      err_tcyce    <= 1'b0;
      err_data     <= 1'b0;
      err_rs_split <= 1'b0;
    end else begin
      e_d  <= e_s;
      rs_d <= rs_s;
      d_d  <= d_s;
      if (rise)
        armed <= 1'b1;
      else if (fall)
        armed <= 1'b0;
      if (rise)
        first_rise <= 1'b0;
      if (rs_s != rs_d)
        as_cnt <= '0;
      else
        as_cnt <= as_cnt + CB'(~&as_cnt);
      if (rise)
        hi_cnt <= ONE_C;
      else if (e_s)
        hi_cnt <= hi_cnt + CB'(~&hi_cnt);
      if (rise)
        cyc_cnt <= ONE_C;
      else
        cyc_cnt <= cyc_cnt + CB'(~&cyc_cnt);
      state <= state_n;
      if (cap && state == ST_4HI) begin
        hi_nyb <= d_s;
        hi_rs  <= rs_s;
      end
      byte_stb     <= stb_n;
      byte_data    <= data_n;
      byte_rs      <= rs_n;
      err_tas      <= (err_tas & ~err_clr) | tas_v;
      err_pweh     <= (err_pweh & ~err_clr) | pweh_v;
      err_tcyce    <= (err_tcyce & ~err_clr) | tcyc_v;
      err_data     <= (err_data & ~err_clr) | data_v;
      err_rs_split <= (err_rs_split & ~err_clr)
                      | split_v;
    end
  end

  assign mode_4bit         = state != ST_8BIT;
  assign hi_nybble_pending = state == ST_4LO;

endmodule
